// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data-memory controller states and defaults.
// Imported by the data-memory access controller and its wait counter.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } dmemState_t;

  localparam int          DMEM_TIMEOUT_DEFAULT = 64;
  localparam logic [31:0] DMEM_ERRDATA         = 32'hDEADBEEF;

  function automatic logic isWordAligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_ctrl_wait_counter.sv
// Cycle counter for the bus WAIT state; terminal flags the last cycle
// before an unacknowledged access is abandoned.
module wait_counter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/dmem_ctrl.sv
// M-stage data-memory access controller: req/ack handshake on a
// variable-latency bus, pipeline stall while pending, error on misalign/timeout.
module dmem_ctrl
  import mips_pkg::*;
#(
  parameter int          TIMEOUT = DMEM_TIMEOUT_DEFAULT,
  parameter logic [31:0] ERRDATA = DMEM_ERRDATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memtoregM,
  input  logic        memwriteM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  output logic        stallM,
  output logic [31:0] rdataM,
  output logic        errM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  dmemState_t  state;
  logic        reqM;
  logic        startAccess;
  logic        misaligned;
  logic        timeoutHit;
  logic        errFlag;
  logic [31:0] rdataReg;

  assign reqM        = memtoregM | memwriteM;
  assign startAccess = (state == IDLE) && reqM && isWordAligned(addrM);
  assign misaligned  = (state == IDLE) && reqM && !isWordAligned(addrM);

  wait_counter #(
    .WIDTH  (8),
    .TIMEOUT(TIMEOUT)
  ) waitCounter (
    .clk     (clk),
    .rst     (rst),
    .clear   (startAccess),
    .enable  ((state == WAIT) && !bus_ack),
    .terminal(timeoutHit)
  );

  // Ack takes priority over expiry; stores never touch the load-data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdataReg  <= '0;
      errFlag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (startAccess) begin
            bus_req   <= 1'b1;
            bus_we    <= memwriteM;
            bus_addr  <= {addrM[31:2], 2'b00};
            bus_wdata <= wdataM;
            errFlag   <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              rdataReg <= bus_rdata;
            end
            errFlag <= 1'b0;
            state   <= DONE;
          end else if (timeoutHit) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              rdataReg <= ERRDATA;
            end
            errFlag <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A misaligned load leaves M in the same cycle, so its error data bypasses the register.
  assign stallM = !rst && (startAccess || (state == WAIT));
  assign errM   = !rst && (((state == DONE) && errFlag) || misaligned);
  assign rdataM = (misaligned && memtoregM) ? ERRDATA : rdataReg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: instance 0 uses the default timeout,
// instance 1 a timeout of 4 for the expiry cases.
module tb_dmem_ctrl;
  logic clk;
  logic rst;

  logic        memtoreg[2];
  logic        memwrite[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];
  logic        stall[2];
  logic [31:0] rdata[2];
  logic        err[2];
  logic        busReq[2];
  logic        busWe[2];
  logic [31:0] busAddr[2];
  logic [31:0] busWdata[2];
  logic        busAck[2];
  logic [31:0] busRdata[2];

  int checkCount = 0;
  int errorCount = 0;

  dmem_ctrl dut0 (
    .clk(clk), .rst(rst),
    .memtoregM(memtoreg[0]), .memwriteM(memwrite[0]),
    .addrM(addr[0]), .wdataM(wdata[0]),
    .stallM(stall[0]), .rdataM(rdata[0]), .errM(err[0]),
    .bus_req(busReq[0]), .bus_we(busWe[0]),
    .bus_addr(busAddr[0]), .bus_wdata(busWdata[0]),
    .bus_ack(busAck[0]), .bus_rdata(busRdata[0])
  );

  dmem_ctrl #(.TIMEOUT(4)) dut1 (
    .clk(clk), .rst(rst),
    .memtoregM(memtoreg[1]), .memwriteM(memwrite[1]),
    .addrM(addr[1]), .wdataM(wdata[1]),
    .stallM(stall[1]), .rdataM(rdata[1]), .errM(err[1]),
    .bus_req(busReq[1]), .bus_we(busWe[1]),
    .bus_addr(busAddr[1]), .bus_wdata(busWdata[1]),
    .bus_ack(busAck[1]), .bus_rdata(busRdata[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One access on instance d; ackDelay counts WAIT cycles before ack (-1: never).
  task automatic applyStimulus(input int d, input logic isLoad, input logic [31:0] a,
                               input logic [31:0] wd, input int ackDelay, input logic [31:0] ackData,
                               output int stallCycles, output int reqCycles,
                               output logic [31:0] doneRdata, output logic doneErr,
                               output logic busStable);
    int waitIdx;
    bit finished;
    stallCycles = 0;
    reqCycles   = 0;
    waitIdx     = 0;
    busStable   = 1'b1;
    finished    = 1'b0;
    doneRdata   = '0;
    doneErr     = 1'b0;
    @(posedge clk); #1;
    memtoreg[d] = isLoad;
    memwrite[d] = !isLoad;
    addr[d]     = a;
    wdata[d]    = wd;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      busAck[d] = 1'b0;
      if (busReq[d]) begin
        reqCycles++;
        if (busAddr[d] !== {a[31:2], 2'b00} || busWe[d] !== !isLoad ||
            (!isLoad && busWdata[d] !== wd))
          busStable = 1'b0;
        if (waitIdx == ackDelay) begin
          busAck[d]   = 1'b1;
          busRdata[d] = ackData;
        end
        waitIdx++;
      end
      if (stall[d]) begin
        stallCycles++;
      end else begin
        doneRdata = rdata[d];
        doneErr   = err[d];
        finished  = 1'b1;
      end
    end
    checkOutput("accessBound", 32'(finished), 32'd1);
    @(posedge clk); #1;
    memtoreg[d] = 1'b0;
    memwrite[d] = 1'b0;
    busAck[d]   = 1'b0;
    @(negedge clk);
    checkOutput("noRestart", 32'(busReq[d]), 32'd0);
  endtask

  int          sc, rc;
  logic [31:0] rd;
  logic        er, st;

  initial begin
    for (int i = 0; i < 2; i++) begin
      memtoreg[i] = 1'b0;
      memwrite[i] = 1'b0;
      addr[i]     = '0;
      wdata[i]    = '0;
      busAck[i]   = 1'b0;
      busRdata[i] = '0;
    end
    rst = 1'b0;
    #2 rst = 1'b1;
    #6;
    checkOutput("rstStall", 32'(stall[0]), 32'd0);
    checkOutput("rstErr", 32'(err[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstBusReq", 32'(busReq[0]), 32'd0);
    checkOutput("rstBusWe", 32'(busWe[0]), 32'd0);
    checkOutput("rstBusAddr", busAddr[0], 32'd0);
    checkOutput("rstBusWdata", busWdata[0], 32'd0);
    checkOutput("rstRdata", rdata[0], 32'd0);

    $display("[TB] aligned load, ack after 3 WAIT cycles");
    applyStimulus(0, 1'b1, 32'h0000_0010, 32'h0, 3, 32'h1234_5678, sc, rc, rd, er, st);
    checkOutput("loadStall", 32'(sc), 32'd5);
    checkOutput("loadReq", 32'(rc), 32'd4);
    checkOutput("loadBusStable", 32'(st), 32'd1);
    checkOutput("loadRdata", rd, 32'h1234_5678);
    checkOutput("loadErr", 32'(er), 32'd0);

    $display("[TB] aligned store, ack on first WAIT cycle");
    applyStimulus(0, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 0, 32'hFFFF_FFFF, sc, rc, rd, er, st);
    checkOutput("storeStall", 32'(sc), 32'd2);
    checkOutput("storeReq", 32'(rc), 32'd1);
    checkOutput("storeBusStable", 32'(st), 32'd1);
    checkOutput("storeRdataKept", rd, 32'h1234_5678);
    checkOutput("storeErr", 32'(er), 32'd0);
    checkOutput("storeBusWdata", busWdata[0], 32'hCAFE_F00D);

    $display("[TB] misaligned load");
    applyStimulus(0, 1'b1, 32'h0000_0013, 32'h0, 0, 32'h0, sc, rc, rd, er, st);
    checkOutput("misStall", 32'(sc), 32'd0);
    checkOutput("misReq", 32'(rc), 32'd0);
    checkOutput("misErr", 32'(er), 32'd1);
    checkOutput("misRdata", rd, 32'hDEAD_BEEF);
    checkOutput("misRdataAfter", rdata[0], 32'h1234_5678);

    $display("[TB] timeout load, TIMEOUT=4");
    applyStimulus(1, 1'b1, 32'h0000_0100, 32'h0, -1, 32'h0, sc, rc, rd, er, st);
    checkOutput("toStall", 32'(sc), 32'd5);
    checkOutput("toReq", 32'(rc), 32'd4);
    checkOutput("toErr", 32'(er), 32'd1);
    checkOutput("toRdata", rd, 32'hDEAD_BEEF);

    $display("[TB] ack on expiry cycle, TIMEOUT=4");
    applyStimulus(1, 1'b1, 32'h0000_0104, 32'h0, 3, 32'h0000_0055, sc, rc, rd, er, st);
    checkOutput("expStall", 32'(sc), 32'd5);
    checkOutput("expErr", 32'(er), 32'd0);
    checkOutput("expRdata", rd, 32'h0000_0055);

    $display("[TB] reset pulse during WAIT");
    @(posedge clk); #1;
    memtoreg[0] = 1'b1;
    addr[0]     = 32'h0000_0040;
    repeat (3) @(negedge clk);
    checkOutput("preResetReq", 32'(busReq[0]), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midRstReq", 32'(busReq[0]), 32'd0);
    checkOutput("midRstStall", 32'(stall[0]), 32'd0);
    memtoreg[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("postRstStall", 32'(stall[0]), 32'd0);
    checkOutput("postRstReq", 32'(busReq[0]), 32'd0);
    checkOutput("postRstRdata", rdata[0], 32'd0);
    applyStimulus(0, 1'b1, 32'h0000_0044, 32'h0, 1, 32'hA5A5_A5A5, sc, rc, rd, er, st);
    checkOutput("recoverStall", 32'(sc), 32'd3);
    checkOutput("recoverRdata", rd, 32'hA5A5_A5A5);
    checkOutput("recoverErr", 32'(er), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
